load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none.
REQ-002 clock  in  1  single clock; all state updates on posedge clock.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  core request present.
REQ-005 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU for loads only).
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  response available.
REQ-011 resp_ready  in  1  core accepts response.
REQ-012 resp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
REQ-013 resp_error  out  1  misaligned or illegal request.
REQ-014 mem_addr  out  32  word-aligned address to data memory, {addr[31:2],2'b00}.
REQ-015 mem_write_enable  out  1  memory writes on posedge clock when high.
REQ-016 mem_write_data  out  32  full word to write.
REQ-017 mem_read_data  in  32  combinational read of word at mem_addr.

Function
REQ-018 Byte lanes SHALL be big-endian: byte at offset o=addr[1:0] occupies word bits [31-8o:24-8o].
REQ-019 States SHALL be IDLE, READ, WRITE, RESP; accept occurs when req_valid && req_ready.
REQ-020 Request latching: addr, funct3, write, and wdata SHALL be captured at accept; later input changes SHALL be ignored.
REQ-021 Misalignment: H/HU with addr[0]=1, W with addr[1:0]!=0, or illegal funct3 (011, 11x, store with BU/HU) -> IDLE->RESP with resp_error=1 and no memory access.
REQ-022 Loads: IDLE->READ->RESP; in READ, mem_addr SHALL be driven and mem_read_data captured at end of the cycle.
REQ-023 SW: IDLE->WRITE->RESP; mem_write_data SHALL be req_wdata.
REQ-024 SB/SH: IDLE->READ->WRITE->RESP as read-modify-write; only the target lanes SHALL be replaced; all other bytes SHALL be preserved.
REQ-025 Lane merge: SB lane o <= wdata[7:0]. SH lane o <= wdata[15:8] and lane o+1 <= wdata[7:0].
REQ-026 Load extraction:
- B/BU: lane o, sign- or zero-extended.
- H/HU: bits [31-8o:16-8o] (o in {0,2}), sign- or zero-extended.
- W: full word.
REQ-027 mem_write_enable SHALL be high for exactly the single WRITE cycle; mem_addr SHALL be held stable through READ and WRITE.
REQ-028 Latency from accept cycle T, measured to first resp_valid cycle:
- load T+2
- SW T+2
- SB/SH T+3
- error T+1
REQ-029 RESP SHALL hold resp_valid, resp_rdata, and resp_error stable until resp_ready. On handshake, go to IDLE; req_ready SHALL rise the next cycle, with no back-to-back accept in the handshake cycle.
REQ-030 All outputs SHALL be registered; no combinational path from req_* to mem_* or resp_*.

Reset
REQ-031 While reset_n=0:
- state=IDLE, req_ready=1, resp_valid=0, resp_error=0.
- resp_rdata=0, mem_addr=0, mem_write_enable=0, mem_write_data=0.
REQ-032 Reset asserted mid-operation (including in WRITE) SHALL drop mem_write_enable immediately and abandon the request with no response.

Verification
REQ-033 Memory word 0x10 = 0x80123456; LB 0x10 -> resp_rdata=0xFFFFFF80 at T+2, error=0.
REQ-034 Same word, LBU 0x11 -> 0x00000012; LH 0x12 -> 0x00003456; LHU 0x10 -> 0x00008012.
REQ-035 SB 0x13 with wdata=0x000000AB:
- READ then a single write of 0x801234AB to mem_addr 0x10.
- resp_valid at T+3.
- A subsequent LW 0x10 returns 0x801234AB.
REQ-036 LW 0x12 or SH 0x11 -> resp_error=1, resp_rdata=0 at T+1, mem_write_enable never asserted, memory unchanged.
REQ-037 resp_ready held low 5 cycles -> resp_valid and data stable, req_ready=0 throughout; after handshake, req_ready=1 next cycle.
REQ-038 reset_n pulled low during WRITE of SW 0x20 -> mem_write_enable=0 asynchronously, all outputs at reset values, no resp_valid after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: RISC-V width loads and stores against a single-port
// word memory with big-endian byte lanes. Sub-word stores are done as
// read-modify-write. Every output is a flop.
module load_store_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned F3W    = 3;
  localparam int unsigned OFFW   = 2;
  localparam int unsigned HALFW  = 16;

  localparam logic [F3W-1:0] F3_B  = 3'b000;
  localparam logic [F3W-1:0] F3_H  = 3'b001;
  localparam logic [F3W-1:0] F3_W  = 3'b010;
  localparam logic [F3W-1:0] F3_BU = 3'b100;
  localparam logic [F3W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic            req_ready_q,  req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_error_q, resp_error_d;
  logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
  logic            mem_we_q,     mem_we_d;
  logic [XLEN-1:0] mem_wdata_q,  mem_wdata_d;

  // Latched request fields; the core may change req_* after accept.
  logic [F3W-1:0]   funct3_q, funct3_d;
  logic [OFFW-1:0]  off_q,    off_d;
  logic             write_q,  write_d;
  logic [HALFW-1:0] wdata_q,  wdata_d;

  logic accept_c;
  logic illegal_c;

  // Misaligned or unsupported width/direction combinations.
  function automatic logic req_illegal(input logic            write,
                                       input logic [F3W-1:0]  f3,
                                       input logic [OFFW-1:0] off);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = write;
      F3_HU:   bad = write | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Extract and extend a load result; lane o sits at bits [31-8o -: 8].
  function automatic logic [XLEN-1:0] load_value(input logic [XLEN-1:0] word,
                                                 input logic [F3W-1:0]  f3,
                                                 input logic [OFFW-1:0] off);
    logic [XLEN-1:0]  b_sh;
    logic [XLEN-1:0]  h_sh;
    logic [7:0]       b;
    logic [HALFW-1:0] h;
    logic [XLEN-1:0]  res;
    b_sh = word >> {~off, 3'b000};
    h_sh = word >> {~off[1], 4'b0000};
    b    = b_sh[7:0];
    h    = h_sh[HALFW-1:0];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'h000000, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lanes of the word read from memory.
  function automatic logic [XLEN-1:0] merge_store(input logic [XLEN-1:0]  word,
                                                  input logic             is_half,
                                                  input logic [OFFW-1:0]  off,
                                                  input logic [HALFW-1:0] wd);
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;
    if (is_half) begin
      mask = 32'h0000_FFFF << {~off[1], 4'b0000};
      ins  = {16'h0000, wd} << {~off[1], 4'b0000};
    end else begin
      mask = 32'h0000_00FF << {~off, 3'b000};
      ins  = {24'h000000, wd[7:0]} << {~off, 3'b000};
    end
    return (word & ~mask) | ins;
  endfunction

  assign accept_c  = req_valid & req_ready_q;
  assign illegal_c = req_illegal(req_write, req_funct3, req_addr[OFFW-1:0]);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    write_d      = write_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          funct3_d = req_funct3;
          off_d    = req_addr[OFFW-1:0];
          write_d  = req_write;
          wdata_d  = req_wdata[HALFW-1:0];
          if (illegal_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_addr_d = {req_addr[XLEN-1:OFFW], 2'b00};
            if (req_write && (req_funct3 == F3_W)) begin
              state_d     = WRITE;
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (write_q) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_store(mem_read_data, funct3_q[0], off_q, wdata_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = load_value(mem_read_data, funct3_q, off_q);
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = '0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_error       = resp_error_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_enable = mem_we_q;
  assign mem_write_data   = mem_wdata_q;

endmodule
